// File: rtl/mlp_acc_pkg.sv
// Shared types and constants for the MLP accelerator load path.
//   ldseq_state_e      : load sequencer FSM states
//   ROWS/BEATS_PER_ROW : load geometry (16 rows, 8 beats per row)
//   MAX_LAYERS         : layer index range 0..7
//   LOAD_TYPE_*        : load_type sideband encoding
package mlp_acc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_L0_IN = 3'd1,
    ST_L0_W  = 3'd2,
    ST_LN_W  = 3'd3,
    ST_DONE  = 3'd4
  } ldseq_state_e;

  localparam int   ROWS             = 16;
  localparam int   BEATS_PER_ROW    = 8;
  localparam int   MAX_LAYERS       = 8;
  localparam int   DATA_W           = 32;
  localparam logic LOAD_TYPE_INPUT  = 1'b1;
  localparam logic LOAD_TYPE_WEIGHT = 1'b0;

  // States in which beats are emitted and host words are accepted.
  function automatic logic is_active(input ldseq_state_e s);
    return (s == ST_L0_IN) || (s == ST_L0_W) || (s == ST_LN_W);
  endfunction

endpackage

// File: rtl/mlp_load_fifo.sv
// Ingress FIFO for the load sequencer.
//   clk, rst      : clock, synchronous active-high reset (flushes pointers)
//   push, wdata   : write side; push while full is honoured only with a pop
//   pop, rdata    : read side; rdata shows the head word, a word written at
//                   edge t is poppable at edge t+1
//   full, empty   : occupancy flags
module mlp_load_fifo
  import mlp_acc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push, do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a word.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mlp_load_sequencer.sv
// Load sequencer feeding MLP_acc_top: tags a flat host word stream with the
// load-protocol sideband (type, row, layer, weight beat) and drives the load
// port. Run = layer 0 (16 rows x {8 input, 8 weight} beats) followed by
// layers 1..last_layer (16 rows x 8 weight beats).
//   clk, rst               : clock, synchronous active-high reset
//   start_i, last_layer_i  : run start pulse (IDLE only), final layer index
//   in_valid_i/in_ready_o/in_data_i : host word handshake
//   load_en_o, load_payload_o, load_type_o, input_load_number_o,
//   layer_number_o, weight_number_o : registered load port
//   busy_o, done_o         : run status
//   stall_cnt_o            : only with MLP_LOAD_STALL_CNT_EN defined;
//                            saturating count of mid-run underflow cycles
module mlp_load_sequencer
  import mlp_acc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        last_layer_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              load_en_o,
  output logic [DATA_W-1:0] load_payload_o,
  output logic              load_type_o,
  output logic [3:0]        input_load_number_o,
  output logic [2:0]        layer_number_o,
  output logic [2:0]        weight_number_o,
  output logic              busy_o,
  output logic              done_o
`ifdef MLP_LOAD_STALL_CNT_EN
  , output logic [15:0]     stall_cnt_o
`endif
);

  localparam logic [2:0] LAST_BEAT = 3'(BEATS_PER_ROW - 1);
  localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);

  ldseq_state_e      state, state_nxt;
  logic [3:0]        row_q, row_d;
  logic [2:0]        beat_q, beat_d;
  logic [2:0]        layer_q, layer_d;
  logic [2:0]        last_q, last_d;
  logic              active, pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign active     = is_active(state);
  assign pop        = active && !fifo_empty;
  assign in_ready_o = active && !fifo_full;

  mlp_load_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid_i && in_ready_o),
    .wdata (in_data_i),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      row_q   <= '0;
      beat_q  <= '0;
      layer_q <= '0;
      last_q  <= '0;
    end else begin
      state   <= state_nxt;
      row_q   <= row_d;
      beat_q  <= beat_d;
      layer_q <= layer_d;
      last_q  <= last_d;
    end
  end

  // Counters only move on an emitted beat; an empty FIFO leaves everything put.
  always_comb begin
    state_nxt = state;
    row_d     = row_q;
    beat_d    = beat_q;
    layer_d   = layer_q;
    last_d    = last_q;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt = ST_L0_IN;
          last_d    = last_layer_i;
          row_d     = '0;
          beat_d    = '0;
          layer_d   = '0;
        end
      end
      ST_L0_IN: begin
        if (pop) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_nxt = ST_L0_W;
        end
      end
      ST_L0_W: begin
        if (pop) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            if (row_q != LAST_ROW) begin
              row_d     = row_q + 1'b1;
              state_nxt = ST_L0_IN;
            end else begin
              row_d = '0;
              if (last_q == '0) begin
                state_nxt = ST_DONE;
              end else begin
                layer_d   = 3'd1;
                state_nxt = ST_LN_W;
              end
            end
          end
        end
      end
      ST_LN_W: begin
        if (pop) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            if (row_q != LAST_ROW) begin
              row_d = row_q + 1'b1;
            end else begin
              row_d = '0;
              if (layer_q == last_q) state_nxt = ST_DONE;
              else                   layer_d   = layer_q + 1'b1;
            end
          end
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Registered load port; fields hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_en_o           <= 1'b0;
      load_payload_o      <= '0;
      load_type_o         <= 1'b0;
      input_load_number_o <= '0;
      layer_number_o      <= '0;
      weight_number_o     <= '0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
    end else begin
      load_en_o <= pop;
      if (pop) begin
        load_payload_o      <= fifo_rdata;
        load_type_o         <= (state == ST_L0_IN) ? LOAD_TYPE_INPUT : LOAD_TYPE_WEIGHT;
        input_load_number_o <= row_q;
        layer_number_o      <= layer_q;
        weight_number_o     <= (state == ST_L0_IN) ? 3'd0 : beat_q;
      end
      // busy drops on the same edge that raises done.
      busy_o <= (state_nxt != ST_IDLE);
      done_o <= (state == ST_DONE);
    end
  end

`ifdef MLP_LOAD_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic        primed;

  // The unavoidable empty cycle right after start is not a host stall, so
  // counting begins only once the run has emitted its first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      primed      <= 1'b0;
    end else if (state == ST_IDLE && start_i) begin
      stall_cnt_q <= '0;
      primed      <= 1'b0;
    end else if (active) begin
      if (pop)                                 primed      <= 1'b1;
      else if (primed && stall_cnt_q != '1)    stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
